id_decode_stage: RTL and testbench
==================================

Name: id_decode_stage

Overview:
- Instruction-decode stage of the 8-bit pipelined processor. It is the producer side of the ID/EX interface.
- Accepts 8-bit instruction bytes from IF and holds the 4x8 register file.
- Resolves operands, with EX forwarding and WB bypass, and drives opcode/rd/data1/data2 into the ID/EX pipeline register.
- Handles the two-byte LDI instruction with a small FSM and latches HALT.

Parameters:
- LDI_OP, 4'h7, opcode whose following byte is an 8-bit immediate
- HALT_OP, 4'hF, opcode that stops issue until reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_instr carries a valid byte this cycle
- in_instr  input  8  instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs
- ex_we  input  1  EX stage will write a register (combinational from EX)
- ex_rd  input  2  EX destination register
- ex_result  input  8  EX result being computed this cycle
- wb_we  input  1  writeback write enable
- wb_rd  input  2  writeback destination register
- wb_data  input  8  writeback data
- out_opcode  output  4  opcode to ID/EX (4'h0 = NOP bubble)
- out_rd  output  2  destination register to ID/EX
- out_data1  output  8  operand A = value of R[rd]
- out_data2  output  8  operand B = value of R[rs], or immediate for LDI
- halted  output  1  HALT has been decoded

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Every state element updates only on the rising edge of clk.
- Reset effects: on the rising edge with reset=1:
  - R0..R3 are cleared to 0.
  - FSM goes to DECODE.
  - Pending LDI fields are cleared.
  - halted is cleared to 0.
  - Reset overrides a simultaneous wb_we write and any in_valid byte.
- Outputs are combinational from state and inputs. While reset=1, and in every bubble cycle, out_opcode=0, out_rd=0, out_data1=0 and out_data2=0.
- Operand resolution, applied independently for each read address a (rd for data1, rs for data2):
  - if ex_we and ex_rd==a, use ex_result;
  - else if wb_we and wb_rd==a, use wb_data;
  - else use R[a].
  - EX has priority over WB.
- Register file write: when wb_we=1 and reset=0, R[wb_rd] <= wb_data at the clock edge. The write is visible to the next cycle's direct read, and to the current cycle's read through the bypass.
- FSM states: DECODE, IMM, HALT.
- DECODE:
  - in_valid=0: bubble, stay in DECODE.
  - in_valid=1 and opcode==HALT_OP: bubble, go to HALT, halted=1 from the next cycle.
  - in_valid=1 and opcode==LDI_OP: bubble; latch rd into pend_rd; go to IMM.
  - in_valid=1 and any other opcode: issue out_opcode=opcode, out_rd=rd, data1 = resolved R[rd], data2 = resolved R[rs]. Stay in DECODE.
- IMM:
  - in_valid=0: bubble, stay in IMM, pend_rd held.
  - in_valid=1: the whole byte is the immediate and is not decoded as an opcode. Issue out_opcode=LDI_OP, out_rd=pend_rd, data1 = resolved R[pend_rd], data2 = in_instr. Go to DECODE.
- HALT: all in_valid bytes are ignored and outputs are bubbles. The register file still accepts wb writes so in-flight instructions drain. Only reset exits HALT.
- Issue rate: one instruction per valid byte, with zero cycles of latency from in_instr to the outputs. LDI uses two valid bytes and produces a single issue on the second. There is no backpressure; IF must not require a ready signal.
- Reset in IMM: the pending LDI is discarded. A byte arriving with reset=1 is ignored. The next valid byte after reset is decoded as an opcode.
- Opcodes other than 0, LDI_OP and HALT_OP pass through unchanged; their meaning belongs to EX.

Test Plan:
- Reset then write checks:
  - Assert reset for 2 cycles with in_valid=1, instr=8'h1B -> all outputs 0, halted=0.
  - After reset, wb_we writes R1=8'h3C, R2=8'h05 on two edges.
  - instr=8'h16 (ADD rd=1 rs=2) -> opcode=1, rd=1, data1=3C, data2=05.
- Forwarding priority: R3=8'h10 in regfile; same cycle ex_we=1, ex_rd=3, ex_result=8'hAA, wb_we=1, wb_rd=3, wb_data=8'h55; instr=8'h2F (rd=3 rs=3) -> data1=data2=AA. Drop ex_we -> data1=data2=55. Next cycle with wb_we=0 -> 55 read from the register file.
- LDI sequence: instr=8'h78 (LDI rd=2) -> bubble. in_valid=0 for 3 cycles -> bubbles. Then in_valid=1, instr=8'hF0 -> opcode=7, rd=2, data2=F0, halted stays 0 because the byte is not decoded as HALT.
- Reset mid-LDI: instr=8'h74, then reset for 1 cycle with in_valid=1, instr=8'h99 -> outputs 0. Next instr=8'h99 -> opcode=9, rd=2, rs=1 operands issued, not treated as an immediate.
- HALT: instr=8'hF0 -> bubble, halted=1 next cycle. Then instr=8'h16 -> bubble. wb_we writes R0=8'h77 and is accepted. After reset, instr=8'h10 -> data1=data2=0, because reset cleared R0.
- NOP and idle: instr=8'h00, and cycles with in_valid=0 -> opcode=0 and all outputs 0 every cycle; FSM remains in DECODE.

Source files
------------

// File: rtl/id_decode_stage.sv
// Instruction-decode stage: register file, operand resolution with EX/WB
// forwarding, two-byte LDI handling and HALT latch. Producer side of ID/EX.
module id_decode_stage #(
  parameter logic [3:0] LDI_OP  = 4'h7,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_instr,
  input  logic       ex_we,
  input  logic [1:0] ex_rd,
  input  logic [7:0] ex_result,
  input  logic       wb_we,
  input  logic [1:0] wb_rd,
  input  logic [7:0] wb_data,
  output logic [3:0] out_opcode,
  output logic [1:0] out_rd,
  output logic [7:0] out_data1,
  output logic [7:0] out_data2,
  output logic       halted
);

  typedef enum logic [1:0] {
    DECODE = 2'd0,
    IMM    = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] pend_rd;
  logic [1:0] pend_rd_next;
  logic [7:0] regs [4];

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;

  assign op = in_instr[7:4];
  assign rd = in_instr[3:2];
  assign rs = in_instr[1:0];

  // EX result wins over WB data, which wins over the stored register
  function automatic logic [7:0] resolve(input logic [1:0] a);
    if (ex_we && (ex_rd == a))
      return ex_result;
    else if (wb_we && (wb_rd == a))
      return wb_data;
    else
      return regs[a];
  endfunction

  // Register file: cleared by reset, otherwise written from writeback (also while halted)
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // FSM state and pending LDI destination
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DECODE;
      pend_rd <= '0;
    end else begin
      state   <= state_next;
      pend_rd <= pend_rd_next;
    end
  end

  // Next-state and issue logic; any non-issuing cycle drives an all-zero bubble
  always_comb begin
    state_next   = state;
    pend_rd_next = pend_rd;
    out_opcode   = '0;
    out_rd       = '0;
    out_data1    = '0;
    out_data2    = '0;
    case (state)
      DECODE: begin
        if (in_valid) begin
          if (op == HALT_OP) begin
            state_next = HALT;
          end else if (op == LDI_OP) begin
            pend_rd_next = rd;
            state_next   = IMM;
          end else if (op != 4'h0) begin
            out_opcode = op;
            out_rd     = rd;
            out_data1  = resolve(rd);
            out_data2  = resolve(rs);
          end
        end
      end
      IMM: begin
        if (in_valid) begin
          out_opcode = LDI_OP;
          out_rd     = pend_rd;
          out_data1  = resolve(pend_rd);
          out_data2  = in_instr;
          state_next = DECODE;
        end
      end
      default: ;
    endcase
    if (reset) begin
      out_opcode = '0;
      out_rd     = '0;
      out_data1  = '0;
      out_data2  = '0;
    end
  end

  assign halted = (state == HALT) && !reset;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed cycle table, then randomized traffic
// compared against a behavioural model of the decode rules.
module tb_id_decode_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_instr;
  logic       ex_we;
  logic [1:0] ex_rd;
  logic [7:0] ex_result;
  logic       wb_we;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic [3:0] out_opcode;
  logic [1:0] out_rd;
  logic [7:0] out_data1;
  logic [7:0] out_data2;
  logic       halted;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.LDI_OP(4'h7), .HALT_OP(4'hF)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_result(ex_result),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_data1(out_data1),
    .out_data2(out_data2), .halted(halted)
  );

  typedef struct {
    logic       rst;
    logic       val;
    logic [7:0] ins;
    logic       exw;
    logic [1:0] exr;
    logic [7:0] exd;
    logic       wbw;
    logic [1:0] wbr;
    logic [7:0] wbd;
    logic [3:0] eop;
    logic [1:0] erd;
    logic [7:0] ed1;
    logic [7:0] ed2;
    logic       eh;
  } vec_t;

  function automatic vec_t v(logic rst, logic val, logic [7:0] ins,
                             logic exw, logic [1:0] exr, logic [7:0] exd,
                             logic wbw, logic [1:0] wbr, logic [7:0] wbd,
                             logic [3:0] eop, logic [1:0] erd,
                             logic [7:0] ed1, logic [7:0] ed2, logic eh);
    vec_t t;
    t.rst = rst; t.val = val; t.ins = ins;
    t.exw = exw; t.exr = exr; t.exd = exd;
    t.wbw = wbw; t.wbr = wbr; t.wbd = wbd;
    t.eop = eop; t.erd = erd; t.ed1 = ed1; t.ed2 = ed2; t.eh = eh;
    return t;
  endfunction

  // Behavioural model state
  logic [7:0] mregs [4];
  bit         mpend;
  logic [1:0] mpend_rd;
  bit         mhalt;

  function automatic logic [7:0] mres(input vec_t t, input logic [1:0] a);
    if (t.exw && t.exr == a) return t.exd;
    if (t.wbw && t.wbr == a) return t.wbd;
    return mregs[a];
  endfunction

  function automatic vec_t predict(input vec_t t);
    vec_t r = t;
    logic [3:0] op = t.ins[7:4];
    r.eop = 0; r.erd = 0; r.ed1 = 0; r.ed2 = 0;
    r.eh  = mhalt && !t.rst;
    if (!t.rst && !mhalt && t.val) begin
      if (mpend) begin
        r.eop = 4'h7; r.erd = mpend_rd;
        r.ed1 = mres(t, mpend_rd); r.ed2 = t.ins;
      end else if (op != 4'h0 && op != 4'h7 && op != 4'hF) begin
        r.eop = op; r.erd = t.ins[3:2];
        r.ed1 = mres(t, t.ins[3:2]); r.ed2 = mres(t, t.ins[1:0]);
      end
    end
    return r;
  endfunction

  task automatic model_update(input vec_t t);
    logic [3:0] op = t.ins[7:4];
    if (t.rst) begin
      for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
      mpend = 0; mpend_rd = 0; mhalt = 0;
    end else begin
      if (t.wbw) mregs[t.wbr] = t.wbd;
      if (!mhalt && t.val) begin
        if (mpend) mpend = 0;
        else if (op == 4'hF) mhalt = 1;
        else if (op == 4'h7) begin mpend = 1; mpend_rd = t.ins[3:2]; end
      end
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then clock it in
  task automatic run_cycle(input vec_t t, input string name, input int idx);
    reset = t.rst; in_valid = t.val; in_instr = t.ins;
    ex_we = t.exw; ex_rd = t.exr; ex_result = t.exd;
    wb_we = t.wbw; wb_rd = t.wbr; wb_data = t.wbd;
    #1;
    checks++;
    if ({out_opcode, out_rd, out_data1, out_data2, halted} !==
        {t.eop, t.erd, t.ed1, t.ed2, t.eh}) begin
      failures++;
      $display("FAIL %s[%0d] instr=%h got op=%h rd=%0d d1=%h d2=%h halted=%b expected op=%h rd=%0d d1=%h d2=%h halted=%b",
               name, idx, t.ins, out_opcode, out_rd, out_data1, out_data2, halted,
               t.eop, t.erd, t.ed1, t.ed2, t.eh);
    end
    @(posedge clk);
    model_update(t);
    @(negedge clk);
  endtask

  vec_t tbl[26];

  initial begin
    // rst val ins  exw exr exd  wbw wbr wbd  | op rd d1 d2 halted
    tbl[0]  = v(1,1,8'h1B, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[1]  = v(1,1,8'h1B, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[2]  = v(0,0,8'h00, 0,0,8'h00, 1,1,8'h3C, 4'h0,0,8'h00,8'h00,0);
    tbl[3]  = v(0,0,8'h00, 0,0,8'h00, 1,2,8'h05, 4'h0,0,8'h00,8'h00,0);
    tbl[4]  = v(0,1,8'h16, 0,0,8'h00, 0,0,8'h00, 4'h1,1,8'h3C,8'h05,0);
    tbl[5]  = v(0,0,8'h00, 0,0,8'h00, 1,3,8'h10, 4'h0,0,8'h00,8'h00,0);
    tbl[6]  = v(0,1,8'h2F, 1,3,8'hAA, 1,3,8'h55, 4'h2,3,8'hAA,8'hAA,0);
    tbl[7]  = v(0,1,8'h2F, 0,3,8'hAA, 1,3,8'h55, 4'h2,3,8'h55,8'h55,0);
    tbl[8]  = v(0,1,8'h2F, 0,0,8'h00, 0,0,8'h00, 4'h2,3,8'h55,8'h55,0);
    tbl[9]  = v(0,1,8'h78, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[10] = v(0,0,8'h78, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[11] = v(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[12] = v(0,0,8'hF0, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[13] = v(0,1,8'hF0, 0,0,8'h00, 0,0,8'h00, 4'h7,2,8'h05,8'hF0,0);
    tbl[14] = v(0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[15] = v(0,1,8'h74, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[16] = v(1,1,8'h99, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[17] = v(0,1,8'h99, 0,0,8'h00, 1,1,8'h42, 4'h9,2,8'h00,8'h42,0);
    tbl[18] = v(0,1,8'hF0, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[19] = v(0,1,8'h16, 0,0,8'h00, 1,0,8'h77, 4'h0,0,8'h00,8'h00,1);
    tbl[20] = v(0,1,8'h10, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,1);
    tbl[21] = v(1,0,8'h00, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[22] = v(0,1,8'h10, 0,0,8'h00, 0,0,8'h00, 4'h1,0,8'h00,8'h00,0);
    tbl[23] = v(0,1,8'h00, 0,0,8'h00, 0,0,8'h00, 4'h0,0,8'h00,8'h00,0);
    tbl[24] = v(0,0,8'h00, 0,0,8'h00, 1,1,8'h99, 4'h0,0,8'h00,8'h00,0);
    tbl[25] = v(0,1,8'h16, 0,0,8'h00, 0,0,8'h00, 4'h1,1,8'h99,8'h00,0);

    mpend = 0; mpend_rd = 0; mhalt = 0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;

    @(negedge clk);
    for (int i = 0; i < 26; i++) run_cycle(tbl[i], "table", i);

    // Randomized traffic with occasional resets; starts from a reset cycle
    for (int n = 0; n < 400; n++) begin
      vec_t t;
      t.rst = (n == 0) || ($urandom_range(0, 29) == 0);
      t.val = ($urandom_range(0, 3) != 0);
      t.ins = 8'($urandom);
      if (t.ins[7:4] == 4'hF && $urandom_range(0, 2) != 0) t.ins[7:4] = 4'h7;
      t.exw = $urandom_range(0, 1) == 1;
      t.exr = 2'($urandom);
      t.exd = 8'($urandom);
      t.wbw = $urandom_range(0, 1) == 1;
      t.wbr = 2'($urandom);
      t.wbd = 8'($urandom);
      t = predict(t);
      run_cycle(t, "random", n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
